// File: rtl/ascon_pkg.sv
// Shared types and defaults for the Ascon permutation round controller.
package ascon_pkg;

    // Round counts for Ascon-p[12] and Ascon-p[8]
    localparam int unsigned ROUNDS_FULL    = 12;
    localparam int unsigned ROUNDS_REDUCED = 8;

    // Five 64-bit words x0..x4; index [2] is the word receiving the round constant
    typedef logic [4:0][63:0] ascon_state_t;

    // Round index driven to the constant addition layer
    typedef logic [3:0] rnd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    // Index of the final round for a given round count
    function automatic rnd_t last_rnd(input int unsigned rounds);
        return rnd_t'(rounds - 1);
    endfunction

endpackage

// File: rtl/ascon_round_controller.sv
// Sequencer for the Ascon permutation: holds the 320-bit state, steps one round
// per clock through an external combinational round datapath, and exchanges
// states over two valid/ready handshakes.
module ascon_round_controller
    import ascon_pkg::*;
#(
    parameter int unsigned ROUNDS_FULL    = ascon_pkg::ROUNDS_FULL,
    parameter int unsigned ROUNDS_REDUCED = ascon_pkg::ROUNDS_REDUCED
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         round_config_i,
    input  ascon_state_t state_i,
    output logic         round_config_o,
    output rnd_t         rnd_o,
    output ascon_state_t round_state_o,
    input  ascon_state_t round_state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
);

    if (ROUNDS_FULL == 0 || ROUNDS_FULL > 16 ||
        ROUNDS_REDUCED == 0 || ROUNDS_REDUCED > 16) begin : g_bad_rounds
        $error("ascon_round_controller: round counts must lie in 1..16");
    end

    localparam rnd_t LAST_FULL    = last_rnd(ROUNDS_FULL);
    localparam rnd_t LAST_REDUCED = last_rnd(ROUNDS_REDUCED);

    ctrl_state_e  st_q, st_d;
    ascon_state_t state_q, state_d;
    rnd_t         rnd_q, rnd_d;
    logic         cfg_q, cfg_d;
    rnd_t         rnd_last;

    // State, round index, config and FSM registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q    <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            cfg_q   <= 1'b1;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            cfg_q   <= cfg_d;
        end
    end

    // Next-state logic: accept in IDLE, one round per cycle in RUN, hold in DONE
    always_comb begin
        st_d     = st_q;
        state_d  = state_q;
        rnd_d    = rnd_q;
        cfg_d    = cfg_q;
        rnd_last = cfg_q ? LAST_FULL : LAST_REDUCED;
        case (st_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = state_i;
                    cfg_d   = round_config_i;
                    rnd_d   = '0;
                    st_d    = RUN;
                end
            end
            RUN: begin
                state_d = round_state_i;
                if (rnd_q == rnd_last) begin
                    st_d = DONE;
                end else begin
                    rnd_d = rnd_t'(rnd_q + 4'd1);
                end
            end
            DONE: begin
                // Result handshake only; a pending request waits for IDLE
                if (out_ready_i) begin
                    st_d  = IDLE;
                    rnd_d = '0;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // Registered outputs decoded from FSM state
    always_comb begin
        in_ready_o     = (st_q == IDLE);
        out_valid_o    = (st_q == DONE);
        busy_o         = (st_q != IDLE);
        round_config_o = cfg_q;
        rnd_o          = rnd_q;
        round_state_o  = state_q;
        state_o        = state_q;
    end

endmodule

// File: tb/tb_ascon_round_controller.sv
// Scoreboard bench for ascon_round_controller with a closed-loop constant-addition datapath.
module tb_ascon_round_controller;
    import ascon_pkg::*;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         round_config;
    ascon_state_t state_in;
    logic         round_config_out;
    rnd_t         rnd;
    ascon_state_t round_state_out;
    ascon_state_t round_state_in;
    logic         out_valid;
    logic         out_ready;
    ascon_state_t state_out;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;
    ascon_state_t exp_q[$];

    // Hand-listed Ascon round constants for rounds 0..11
    localparam logic [7:0] RC [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                       8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    ascon_round_controller #(
        .ROUNDS_FULL   (12),
        .ROUNDS_REDUCED(8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .round_config_i(round_config),
        .state_i       (state_in),
        .round_config_o(round_config_out),
        .rnd_o         (rnd),
        .round_state_o (round_state_out),
        .round_state_i (round_state_in),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .state_o       (state_out),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural constant addition layer: p[8] rounds use constants 4..11
    function automatic ascon_state_t cal(input logic cfg, input rnd_t r, input ascon_state_t s);
        logic [3:0]   i;
        ascon_state_t o;
        i    = cfg ? r : rnd_t'(r + 4'd4);
        o    = s;
        o[2] = s[2] ^ {56'd0, 4'hf - i, i};
        return o;
    endfunction

    always_comb round_state_in = cal(round_config_out, rnd, round_state_out);

    // Reference permutation from the constant table
    function automatic ascon_state_t ref_perm(input logic cfg, input ascon_state_t s);
        ascon_state_t o;
        o = s;
        for (int j = (cfg ? 0 : 4); j < 12; j++) o[2] = o[2] ^ {56'd0, RC[j]};
        return o;
    endfunction

    task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every completed result transfer against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", 320'd1, 320'd0);
            end else begin
                check("result_state", state_out, exp_q.pop_front());
            end
        end
    end

    // One request: optional input churn while busy, backpressure and turnaround
    task automatic do_req(input logic cfg, input ascon_state_t st, input int hold,
                          input bit mess, input bit turn);
        int           n;
        ascon_state_t exp;
        n            = cfg ? 12 : 8;
        exp          = ref_perm(cfg, st);
        in_valid     = 1'b1;
        round_config = cfg;
        state_in     = st;
        out_ready    = 1'b0;
        exp_q.push_back(exp);
        @(negedge clk);
        check("ready_before_accept", 320'(in_ready), 320'd1);
        tick;
        in_valid = mess;
        for (int k = 0; k < n; k++) begin
            if (mess) begin
                round_config = ~round_config;
                state_in     = {5{64'hdead_beef_0000_0000 | 64'(k)}};
            end
            @(negedge clk);
            check("rnd_seq", 320'(rnd), 320'(k));
            check("cfg_out", 320'(round_config_out), 320'(cfg));
            check("run_flags", {out_valid, in_ready, busy}, 3'b001);
            tick;
        end
        @(negedge clk);
        check("latency_valid", 320'(out_valid), 320'd1);
        for (int h = 0; h < hold; h++) begin
            tick;
            @(negedge clk);
            check("hold_flags", {out_valid, in_ready, busy}, 3'b101);
            check("hold_rnd", 320'(rnd), 320'(n - 1));
            check("hold_state", state_out, exp);
        end
        tick;
        out_ready = 1'b1;
        in_valid  = mess | turn;
        @(negedge clk);
        tick;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_flags", {out_valid, in_ready, busy}, 3'b010);
        check("idle_rnd", 320'(rnd), 320'd0);
        check("idle_state_kept", state_out, exp);
        check("single_transfer", 320'(exp_q.size()), 320'd0);
        in_valid = 1'b0;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ascon_state_t p;
        rst          = 1'b1;
        in_valid     = 1'b0;
        round_config = 1'b0;
        state_in     = '0;
        out_ready    = 1'b0;
        #2;
        check("reset_flags", {out_valid, busy}, 2'b00);
        check("reset_rnd", 320'(rnd), 320'd0);
        check("reset_cfg", 320'(round_config_out), 320'd1);
        check("reset_state", round_state_out, 320'd0);
        #5 rst = 1'b0;
        tick;
        @(negedge clk);
        check("ready_after_reset", 320'(in_ready), 320'd1);
        tick;

        // Ascon-p[12] on all-zero state
        do_req(1'b1, '0, 0, 1'b0, 1'b0);

        // Ascon-p[8] on a mixed pattern with 5 cycles of backpressure
        p = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 64'h0f1e_2d3c_4b5a_6978,
             64'haaaa_5555_cccc_3333, 64'h8000_0000_0000_0001};
        do_req(1'b0, p, 5, 1'b0, 1'b0);

        // Ascon-p[12] with inputs churning while busy and a same-cycle request at handshake
        p = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_aaaa_bbbb_cccc,
             64'hdddd_eeee_ffff_0000, 64'h0102_0304_0506_0708};
        do_req(1'b1, p, 1, 1'b1, 1'b1);

        // Ascon-p[8] with churning inputs: the latched config must stay 0
        do_req(1'b0, p, 0, 1'b1, 1'b0);

        // Reset while rnd_o = 5 of a p[12] run
        in_valid     = 1'b1;
        round_config = 1'b1;
        state_in     = p;
        @(negedge clk);
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick;
        @(negedge clk);
        check("pre_reset_rnd", 320'(rnd), 320'd5);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_flags", {out_valid, busy}, 2'b00);
        check("midrun_reset_rnd", 320'(rnd), 320'd0);
        check("midrun_reset_state", round_state_out, 320'd0);
        #4 rst = 1'b0;
        tick;
        @(negedge clk);
        check("post_reset_flags", {out_valid, in_ready, busy}, 3'b010);
        tick;
        do_req(1'b1, {64'h0, 64'h0, 64'h0000_0000_0000_00ff, 64'h0, 64'h1}, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
